me_pe_array_sched: RTL

- Scheduler for the motion-estimation PE array, one instance per array.
- Drives the shared PE control lines: in_curr_enable, CB_select, abs_Control, change_ref and ref_input_Control.
- Double-buffers current-block pairs. While the array searches one bank (CB1_1/CB1_2, or CB1_3/CB1_4), it preloads the next pair into the other bank.
- Tags every valid absolute-difference cycle with a candidate index and a CB index for the downstream SAD accumulator.

---
 rtl/me_pe_array_sched_pkg.sv | 28 ++
 rtl/me_pe_array_sched_if.sv | 44 ++++
 rtl/me_cur_load_ctrl.sv | 62 ++++++
 rtl/me_pe_array_sched.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/me_pe_array_sched_pkg.sv
`default_nettype none
// ============================================================================
// me_sched_pkg : shared types and constants for the ME PE-array scheduler
// Rev 1.0
// ============================================================================
package me_sched_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LOAD      = 3'd1,
        ST_SEARCH    = 3'd2,
        ST_WAIT_LOAD = 3'd3,
        ST_DRAIN     = 3'd4,
        ST_DONE      = 3'd5
    } sched_state_t;

    localparam logic CB_A     = 1'b1;
    localparam logic CB_B     = 1'b0;
    localparam logic REF_ADJ1 = 1'b0;
    localparam logic REF_ADJ8 = 1'b1;

    // Index width that never collapses to zero bits.
    function automatic int idx_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/me_pe_array_sched_if.sv
`default_nettype none
// ============================================================================
// me_pe_array_sched_if : job handshake, PE control lines and SAD tag bundle
// Rev 1.0
// ============================================================================
interface me_pe_array_sched_if #(
    parameter int SEARCH_W  = 8,
    parameter int SEARCH_H  = 8,
    parameter int NUM_PAIRS = 2
) ();
    import me_sched_pkg::*;

    localparam int CAND_W = idx_w(SEARCH_W * SEARCH_H);
    localparam int CB_W   = idx_w(2 * NUM_PAIRS);

    logic              start;
    logic              abort;
    logic              cur_valid;
    logic              cur_ready;
    logic              in_curr_enable;
    logic              CB_select;
    logic [1:0]        abs_Control;
    logic              change_ref;
    logic              ref_input_Control;
    logic              sad_valid;
    logic [CAND_W-1:0] cand_idx;
    logic [CB_W-1:0]   cb_idx;
    logic              busy;
    logic              done;

    modport master (
        input  start, abort, cur_valid,
        output cur_ready, in_curr_enable, CB_select, abs_Control, change_ref,
               ref_input_Control, sad_valid, cand_idx, cb_idx, busy, done
    );

    modport slave (
        output start, abort, cur_valid,
        input  cur_ready, in_curr_enable, CB_select, abs_Control, change_ref,
               ref_input_Control, sad_valid, cand_idx, cb_idx, busy, done
    );

endinterface
`default_nettype wire

// File: rtl/me_cur_load_ctrl.sv
`default_nettype none
// ============================================================================
// me_cur_load_ctrl : current-block pair loader (shared load counter + bank)
// Rev 1.0
// ============================================================================
module me_cur_load_ctrl
    import me_sched_pkg::*;
#(
    parameter int ARRAY_ROWS = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic abort,
    input  logic load_begin,
    input  logic begin_bank,
    input  logic cur_valid,
    output logic cur_ready,
    output logic in_curr_enable,
    output logic load_bank,
    output logic load_done
);

    localparam int               CNT_W    = idx_w(ARRAY_ROWS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ARRAY_ROWS - 1);

    logic             r_active;
    logic             r_bank;
    logic [CNT_W-1:0] r_cnt;
    logic             w_en;

    assign w_en           = cur_valid & r_active;
    assign cur_ready      = r_active;
    assign in_curr_enable = w_en;
    assign load_bank      = r_bank;
    assign load_done      = w_en && (r_cnt == CNT_LAST);

    // A new load request wins over the final enable of the previous load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_active <= 1'b0;
            r_bank   <= 1'b0;
            r_cnt    <= '0;
        end else if (abort) begin
            r_active <= 1'b0;
            r_bank   <= 1'b0;
            r_cnt    <= '0;
        end else if (load_begin) begin
            r_active <= 1'b1;
            r_bank   <= begin_bank;
            r_cnt    <= '0;
        end else if (w_en) begin
            if (r_cnt == CNT_LAST) begin
                r_cnt    <= '0;
                r_active <= 1'b0;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/me_pe_array_sched.sv
`default_nettype none
// ============================================================================
// me_pe_array_sched : ME PE-array scheduler, double-buffered CB pair search
// Rev 1.0
// ============================================================================
module me_pe_array_sched
    import me_sched_pkg::*;
#(
    parameter int ARRAY_ROWS = 8,
    parameter int SEARCH_W   = 8,
    parameter int SEARCH_H   = 8,
    parameter int NUM_PAIRS  = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    me_pe_array_sched_if.master  bus
);

    localparam int NUM_CAND = SEARCH_W * SEARCH_H;
    localparam int CAND_W   = idx_w(NUM_CAND);
    localparam int COL_W    = idx_w(SEARCH_W);
    localparam int PAIR_W   = idx_w(NUM_PAIRS);
    localparam int CB_W     = idx_w(2 * NUM_PAIRS);

    localparam logic [CAND_W-1:0] C_LAST    = CAND_W'(NUM_CAND - 1);
    localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(SEARCH_W - 1);
    localparam logic [PAIR_W-1:0] PAIR_LAST = PAIR_W'(NUM_PAIRS - 1);

    sched_state_t      r_state;
    sched_state_t      w_next;
    logic [CAND_W-1:0] r_c;
    logic [COL_W-1:0]  r_col;
    logic              r_pass;
    logic [PAIR_W-1:0] r_pair;
    logic              r_search_bank;

    logic              r_sad_valid;
    logic [CAND_W-1:0] r_cand;
    logic [CB_W-1:0]   r_cb;

    logic w_load_begin, w_begin_bank;
    logic w_cur_ready, w_in_curr_enable, w_load_bank, w_load_done;
    logic w_pass_end, w_pair_end, w_last_pair, w_preload_ok;
    logic w_more_after_cur, w_more_after_next;
    logic w_busy, w_done, w_change_ref, w_ref_ctrl, w_cb_select;
    logic [1:0] w_abs;

    me_cur_load_ctrl #(
        .ARRAY_ROWS (ARRAY_ROWS)
    ) u_load (
        .clk            (clk),
        .rst_n          (rst_n),
        .abort          (bus.abort),
        .load_begin     (w_load_begin),
        .begin_bank     (w_begin_bank),
        .cur_valid      (bus.cur_valid),
        .cur_ready      (w_cur_ready),
        .in_curr_enable (w_in_curr_enable),
        .load_bank      (w_load_bank),
        .load_done      (w_load_done)
    );

    assign w_pass_end        = (r_state == ST_SEARCH) && (r_c == C_LAST);
    assign w_pair_end        = w_pass_end && r_pass;
    assign w_last_pair       = (r_pair == PAIR_LAST);
    // A preload finishing on the very last search cycle still counts as done.
    assign w_preload_ok      = !w_cur_ready || w_load_done;
    assign w_more_after_cur  = (int'(r_pair) + 1) < NUM_PAIRS;
    assign w_more_after_next = (int'(r_pair) + 2) < NUM_PAIRS;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:      if (bus.start) w_next = ST_LOAD;
            ST_LOAD:      if (w_load_done) w_next = ST_SEARCH;
            ST_SEARCH: begin
                if (w_pair_end) begin
                    if (w_last_pair)        w_next = ST_DRAIN;
                    else if (!w_preload_ok) w_next = ST_WAIT_LOAD;
                end
            end
            ST_WAIT_LOAD: if (w_load_done) w_next = ST_SEARCH;
            ST_DRAIN:     w_next = ST_DONE;
            ST_DONE:      w_next = ST_IDLE;
            default:      w_next = ST_IDLE;
        endcase
        if (bus.abort) w_next = ST_IDLE;
    end

    // Preload of the next pair always targets the bank not being searched.
    always_comb begin
        w_load_begin = 1'b0;
        w_begin_bank = CB_A;
        if (!bus.abort) begin
            case (r_state)
                ST_IDLE: if (bus.start) begin
                    w_load_begin = 1'b1;
                    w_begin_bank = CB_A;
                end
                ST_LOAD: if (w_load_done && w_more_after_cur) begin
                    w_load_begin = 1'b1;
                    w_begin_bank = CB_B;
                end
                ST_SEARCH: if (w_pair_end && !w_last_pair && w_preload_ok && w_more_after_next) begin
                    w_load_begin = 1'b1;
                    w_begin_bank = r_search_bank;
                end
                ST_WAIT_LOAD: if (w_load_done && w_more_after_cur) begin
                    w_load_begin = 1'b1;
                    w_begin_bank = ~r_search_bank;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_c           <= '0;
            r_col         <= '0;
            r_pass        <= 1'b0;
            r_pair        <= '0;
            r_search_bank <= 1'b0;
        end else if (bus.abort || (r_state == ST_DONE)) begin
            r_c           <= '0;
            r_col         <= '0;
            r_pass        <= 1'b0;
            r_pair        <= '0;
            r_search_bank <= 1'b0;
        end else begin
            case (r_state)
                ST_LOAD: if (w_load_done) r_search_bank <= CB_A;
                ST_SEARCH: begin
                    if (r_c == C_LAST) begin
                        r_c   <= '0;
                        r_col <= '0;
                        if (!r_pass) begin
                            r_pass <= 1'b1;
                        end else begin
                            r_pass <= 1'b0;
                            if (!w_last_pair) begin
                                r_pair        <= r_pair + PAIR_W'(1);
                                r_search_bank <= ~r_search_bank;
                            end
                        end
                    end else begin
                        r_c   <= r_c + CAND_W'(1);
                        r_col <= (r_col == COL_LAST) ? '0 : r_col + COL_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        w_busy       = (r_state != ST_IDLE);
        w_done       = (r_state == ST_DONE);
        w_change_ref = (r_state == ST_SEARCH);
        w_ref_ctrl   = REF_ADJ1;
        w_abs        = 2'b00;
        if (w_change_ref) begin
            w_ref_ctrl = (r_col == '0) ? REF_ADJ8 : REF_ADJ1;
            w_abs      = {r_search_bank == CB_B, r_pass};
        end
        w_cb_select = 1'b0;
        if (w_cur_ready)
            w_cb_select = w_load_bank;
        else if ((r_state == ST_SEARCH) || (r_state == ST_WAIT_LOAD))
            w_cb_select = r_search_bank;
    end

    // Tags trail change_ref by one cycle to line up with the PE ref_pix register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sad_valid <= 1'b0;
            r_cand      <= '0;
            r_cb        <= '0;
        end else if (bus.abort || !w_change_ref) begin
            r_sad_valid <= 1'b0;
            r_cand      <= '0;
            r_cb        <= '0;
        end else begin
            r_sad_valid <= 1'b1;
            r_cand      <= r_c;
            r_cb        <= CB_W'({r_pair, r_pass});
        end
    end

    assign bus.cur_ready         = w_cur_ready;
    assign bus.in_curr_enable    = w_in_curr_enable;
    assign bus.CB_select         = w_cb_select;
    assign bus.abs_Control       = w_abs;
    assign bus.change_ref        = w_change_ref;
    assign bus.ref_input_Control = w_ref_ctrl;
    assign bus.sad_valid         = r_sad_valid;
    assign bus.cand_idx          = r_cand;
    assign bus.cb_idx            = r_cb;
    assign bus.busy              = w_busy;
    assign bus.done              = w_done;

endmodule
`default_nettype wire
